// File: rtl/icache_pkg.sv
// Shared constants and FSM encoding for the direct-mapped L1 instruction cache.
// Default geometry: 16 sets, 128-bit blocks, 32-bit words and addresses.
package icache_pkg;

    localparam int ICACHE_WORD_BITS     = 32;
    localparam int ICACHE_ADDR_BITS     = 32;
    localparam int IBLOCK_BITS          = 128;
    localparam int ICACHE_SETS          = 16;
    localparam int ICACHE_INDEX_SIZE    = $clog2(ICACHE_SETS);
    localparam int IBLOCK_WORDS         = IBLOCK_BITS / ICACHE_WORD_BITS;
    localparam int IBLOCK_WORD_OFF_SIZE = $clog2(IBLOCK_WORDS);
    localparam int ICACHE_TAG_SIZE      = ICACHE_ADDR_BITS - 2 - IBLOCK_WORD_OFF_SIZE - ICACHE_INDEX_SIZE;
    localparam int IMEM_BLOCK_ADDR_DEF  = ICACHE_ADDR_BITS - 2 - IBLOCK_WORD_OFF_SIZE;

    typedef enum logic [1:0] {
        IC_IDLE    = 2'd0,
        IC_REFILL  = 2'd1,
        IC_RELEASE = 2'd2
    } ic_state_e;

endpackage

// File: rtl/icache_array.sv
// Valid/tag/data storage for the instruction cache: one combinational read port,
// one synchronous write port and a synchronous invalidate-all.
module icache_array
    import icache_pkg::*;
#(
    parameter int SETS       = ICACHE_SETS,
    parameter int TAG_BITS   = ICACHE_TAG_SIZE,
    parameter int BLOCK_BITS = IBLOCK_BITS
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [$clog2(SETS)-1:0]     rd_idx,
    output logic                        rd_valid,
    output logic [TAG_BITS-1:0]         rd_tag,
    output logic [BLOCK_BITS-1:0]       rd_data,
    input  logic                        wr_en,
    input  logic [$clog2(SETS)-1:0]     wr_idx,
    input  logic [TAG_BITS-1:0]         wr_tag,
    input  logic [BLOCK_BITS-1:0]       wr_data,
    input  logic                        clear_all
);

    logic [SETS-1:0]       valid_r;
    logic [TAG_BITS-1:0]   tag_r  [SETS];
    logic [BLOCK_BITS-1:0] data_r [SETS];

    // Valid bits: the only reset state in the array; clear-all wins over a fill.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            valid_r <= '0;
        end else if (clear_all) begin
            valid_r <= '0;
        end else if (wr_en) begin
            valid_r[wr_idx] <= 1'b1;
        end else begin
            valid_r <= valid_r;
        end
    end

    // Tag and data payload, deliberately left without reset.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            tag_r[wr_idx]  <= wr_tag;
            data_r[wr_idx] <= wr_data;
        end
    end

    assign rd_valid = valid_r[rd_idx];
    assign rd_tag   = tag_r[rd_idx];
    assign rd_data  = data_r[rd_idx];

endmodule

// File: rtl/icache.sv
// Direct-mapped read-only L1 instruction cache with block refill from Imem.
// Optional hit/miss counters are enabled by defining ICACHE_STATS_EN.
module icache
    import icache_pkg::*;
#(
    parameter int SETS                 = ICACHE_SETS,
    parameter int WORD_BITS            = ICACHE_WORD_BITS,
    parameter int ADDR_BITS            = ICACHE_ADDR_BITS,
    parameter int IBLOCK_SIZE_BITS     = IBLOCK_BITS,
    parameter int IMEM_BLOCK_ADDR_SIZE = IMEM_BLOCK_ADDR_DEF
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic                            cpu_ren,
    input  logic [ADDR_BITS-1:0]            cpu_addr,
    input  logic                            flush,
    output logic [WORD_BITS-1:0]            cpu_instr,
    output logic                            cpu_stall,
    output logic                            mem_ren,
    output logic [IMEM_BLOCK_ADDR_SIZE-1:0] mem_block_address,
    input  logic                            mem_ready,
    input  logic [IBLOCK_SIZE_BITS-1:0]     mem_dout
`ifdef ICACHE_STATS_EN
    ,
    output logic [31:0]                     hit_count,
    output logic [31:0]                     miss_count
`endif
);

    localparam int WOFF_BITS  = $clog2(IBLOCK_SIZE_BITS / WORD_BITS);
    localparam int INDEX_BITS = $clog2(SETS);
    localparam int OFF_BITS   = 2 + WOFF_BITS;
    localparam int TAG_BITS   = ADDR_BITS - OFF_BITS - INDEX_BITS;

    ic_state_e state_r;
    ic_state_e state_s;

    logic [WOFF_BITS-1:0]            word_off_s;
    logic [INDEX_BITS-1:0]           idx_s;
    logic [TAG_BITS-1:0]             tag_s;
    logic [IMEM_BLOCK_ADDR_SIZE-1:0] blk_s;
    logic                            byte_off_unused_s;

    logic [INDEX_BITS-1:0]           idx_r;
    logic [TAG_BITS-1:0]             tag_r;
    logic [IMEM_BLOCK_ADDR_SIZE-1:0] blk_r;

    logic                            rd_valid_s;
    logic [TAG_BITS-1:0]             rd_tag_s;
    logic [IBLOCK_SIZE_BITS-1:0]     rd_data_s;
    logic                            hit_s;
    logic                            miss_s;
    logic                            fill_s;
    logic                            clear_s;

    assign word_off_s        = cpu_addr[2 +: WOFF_BITS];
    assign idx_s             = cpu_addr[OFF_BITS +: INDEX_BITS];
    assign tag_s             = cpu_addr[ADDR_BITS-1 -: TAG_BITS];
    assign blk_s             = cpu_addr[OFF_BITS +: IMEM_BLOCK_ADDR_SIZE];
    assign byte_off_unused_s = ^cpu_addr[1:0];

    icache_array #(
        .SETS       (SETS),
        .TAG_BITS   (TAG_BITS),
        .BLOCK_BITS (IBLOCK_SIZE_BITS)
    ) u_array (
        .clock     (clock),
        .reset     (reset),
        .rd_idx    (idx_s),
        .rd_valid  (rd_valid_s),
        .rd_tag    (rd_tag_s),
        .rd_data   (rd_data_s),
        .wr_en     (fill_s),
        .wr_idx    (idx_r),
        .wr_tag    (tag_r),
        .wr_data   (mem_dout),
        .clear_all (clear_s)
    );

    assign hit_s     = cpu_ren & rd_valid_s & (rd_tag_s == tag_s);
    assign cpu_instr = rd_data_s[word_off_s*WORD_BITS +: WORD_BITS];

    // FSM state register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r <= IC_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // FSM next-state logic; flush suppresses miss_s, so it keeps IDLE.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IC_IDLE: begin
                if (miss_s) begin
                    state_s = IC_REFILL;
                end else begin
                    state_s = IC_IDLE;
                end
            end
            IC_REFILL: begin
                if (mem_ready) begin
                    state_s = IC_RELEASE;
                end else begin
                    state_s = IC_REFILL;
                end
            end
            IC_RELEASE: state_s = IC_IDLE;
            default:    state_s = IC_IDLE;
        endcase
    end

    // FSM outputs; the RELEASE cycle drops mem_ren so Imem restarts its latency.
    always_comb begin
        mem_ren   = 1'b0;
        cpu_stall = 1'b1;
        miss_s    = 1'b0;
        fill_s    = 1'b0;
        clear_s   = 1'b0;
        case (state_r)
            IC_IDLE: begin
                cpu_stall = (cpu_ren & ~hit_s) | flush;
                clear_s   = flush;
                miss_s    = ~flush & cpu_ren & ~hit_s;
            end
            IC_REFILL: begin
                mem_ren = 1'b1;
                fill_s  = mem_ready;
            end
            IC_RELEASE: begin
                mem_ren = 1'b0;
            end
            default: begin
                mem_ren = 1'b0;
            end
        endcase
    end

    // Miss context capture: the refill completes to this address regardless of cpu_addr.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            idx_r <= '0;
            tag_r <= '0;
            blk_r <= '0;
        end else if (miss_s) begin
            idx_r <= idx_s;
            tag_r <= tag_s;
            blk_r <= blk_s;
        end else begin
            idx_r <= idx_r;
            tag_r <= tag_r;
            blk_r <= blk_r;
        end
    end

    assign mem_block_address = blk_r;

`ifdef ICACHE_STATS_EN
    // Free-running wrap-around hit/miss counters.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            hit_count  <= 32'd0;
            miss_count <= 32'd0;
        end else begin
            if ((state_r == IC_IDLE) && hit_s && !flush) begin
                hit_count <= hit_count + 32'd1;
            end
            if (miss_s) begin
                miss_count <= miss_count + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_icache.sv
// Directed bench for icache with a 3-cycle Imem model; stats checks are
// compiled in when ICACHE_STATS_EN is defined.
module tb_icache;

    logic         clock;
    logic         reset;
    logic         cpu_ren;
    logic [31:0]  cpu_addr;
    logic         flush;
    logic [31:0]  cpu_instr;
    logic         cpu_stall;
    logic         mem_ren;
    logic [27:0]  mem_block_address;
    logic         mem_ready;
    logic [127:0] mem_dout;
`ifdef ICACHE_STATS_EN
    logic [31:0]  hit_count;
    logic [31:0]  miss_count;
`endif

    int total;
    int bad;
    int mem_cnt;

    icache dut (
        .clock             (clock),
        .reset             (reset),
        .cpu_ren           (cpu_ren),
        .cpu_addr          (cpu_addr),
        .flush             (flush),
        .cpu_instr         (cpu_instr),
        .cpu_stall         (cpu_stall),
        .mem_ren           (mem_ren),
        .mem_block_address (mem_block_address),
        .mem_ready         (mem_ready),
        .mem_dout          (mem_dout)
`ifdef ICACHE_STATS_EN
        ,
        .hit_count         (hit_count),
        .miss_count        (miss_count)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [31:0] word_of(input logic [27:0] b, input int w);
        return {8'hC0, b[15:0], 8'(w)};
    endfunction

    // Imem: latency counter cleared whenever ren is low, ready after 3 counted cycles
    always @(posedge clock) begin
        if (!mem_ren) mem_cnt <= 0;
        else if (mem_cnt < 3) mem_cnt <= mem_cnt + 1;
    end
    assign mem_ready = mem_ren && (mem_cnt == 3);

    always_comb begin
        mem_dout = '0;
        for (int w = 0; w < 4; w++) mem_dout[w*32 +: 32] = word_of(mem_block_address, w);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One fetch starting at the next negedge; counts stalled cycles and mem_ren cycles.
    task automatic fetch(input logic [31:0] a, output int stalls, output int rens,
                         output logic [27:0] blk, output logic [31:0] instr);
        stalls = 0;
        rens   = 0;
        blk    = '0;
        @(negedge clock);
        cpu_addr = a;
        cpu_ren  = 1'b1;
        #1;
        while (cpu_stall && stalls < 40) begin
            stalls++;
            if (mem_ren) begin
                rens++;
                blk = mem_block_address;
            end
            @(negedge clock);
            #1;
        end
        check("fetch_bound", {63'd0, cpu_stall}, 64'd0);
        instr = cpu_instr;
    endtask

    int          st;
    int          rn;
    logic [27:0] bk;
    logic [31:0] ins;

    initial begin
        total    = 0;
        bad      = 0;
        mem_cnt  = 0;
        reset    = 1'b0;
        cpu_ren  = 1'b0;
        flush    = 1'b0;
        cpu_addr = 32'd0;

        repeat (2) @(negedge clock);
        #1;
        check("rst_mem_ren", {63'd0, mem_ren}, 64'd0);
        check("rst_blk", {36'd0, mem_block_address}, 64'd0);
        check("rst_stall_idle", {63'd0, cpu_stall}, 64'd0);
        cpu_ren = 1'b1;
        #1;
        check("rst_stall_ren", {63'd0, cpu_stall}, 64'd1);
        @(negedge clock);
        cpu_ren = 1'b0;
        reset   = 1'b1;

        // cold miss on block 1
        fetch(32'h10, st, rn, bk, ins);
        check("cold_stall", 64'(st), 64'd6);
        check("cold_ren", 64'(rn), 64'd4);
        check("cold_blk", {36'd0, bk}, 64'd1);
        check("cold_instr", {32'd0, ins}, {32'd0, word_of(28'd1, 0)});

        // sequential hits in block 1
        for (int w = 1; w < 4; w++) begin
            fetch(32'h10 + 32'(4*w), st, rn, bk, ins);
            check("seq_stall", 64'(st), 64'd0);
            check("seq_ren", 64'(rn), 64'd0);
            check("seq_instr", {32'd0, ins}, {32'd0, word_of(28'd1, w)});
        end
        @(negedge clock);
        cpu_ren = 1'b0;
        #1;
`ifdef ICACHE_STATS_EN
        check("stats_hit", {32'd0, hit_count}, 64'd4);
        check("stats_miss", {32'd0, miss_count}, 64'd1);
`endif

        // conflict eviction: 0x110 shares index 1 with 0x10
        fetch(32'h110, st, rn, bk, ins);
        check("evict_stall", 64'(st), 64'd6);
        check("evict_blk", {36'd0, bk}, 64'h11);
        check("evict_instr", {32'd0, ins}, {32'd0, word_of(28'h11, 0)});
        fetch(32'h10, st, rn, bk, ins);
        check("refetch_stall", 64'(st), 64'd6);
        check("refetch_instr", {32'd0, ins}, {32'd0, word_of(28'd1, 0)});
        fetch(32'h18, st, rn, bk, ins);
        check("refetch_hit_stall", 64'(st), 64'd0);
        check("refetch_hit_instr", {32'd0, ins}, {32'd0, word_of(28'd1, 2)});

        // flush
        @(negedge clock);
        cpu_ren = 1'b0;
        flush   = 1'b1;
        #1;
        check("flush_stall", {63'd0, cpu_stall}, 64'd1);
        @(negedge clock);
        flush = 1'b0;
        #1;
        check("post_flush_idle_stall", {63'd0, cpu_stall}, 64'd0);
        fetch(32'h10, st, rn, bk, ins);
        check("post_flush_stall", 64'(st), 64'd6);
        check("post_flush_instr", {32'd0, ins}, {32'd0, word_of(28'd1, 0)});

        // reset asserted mid-refill of block 2
        @(negedge clock);
        cpu_addr = 32'h20;
        cpu_ren  = 1'b1;
        @(negedge clock);
        #1;
        check("mid_mem_ren", {63'd0, mem_ren}, 64'd1);
        check("mid_blk", {36'd0, mem_block_address}, 64'd2);
        reset = 1'b0;
        #1;
        check("mid_rst_mem_ren", {63'd0, mem_ren}, 64'd0);
        check("mid_rst_blk", {36'd0, mem_block_address}, 64'd0);
        check("mid_rst_stall", {63'd0, cpu_stall}, 64'd1);
        cpu_ren = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        fetch(32'h10, st, rn, bk, ins);
        check("post_rst_stall", 64'(st), 64'd6);
        check("post_rst_instr", {32'd0, ins}, {32'd0, word_of(28'd1, 0)});
        fetch(32'h24, st, rn, bk, ins);
        check("post_rst_blk2_stall", 64'(st), 64'd6);
        check("post_rst_blk2_instr", {32'd0, ins}, {32'd0, word_of(28'd2, 1)});

        @(negedge clock);
        cpu_ren = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/icache.md
# icache

Direct-mapped, read-only L1 instruction cache; the initiator side of the instruction-memory block-read protocol. It serves instruction fetches from the core and, on a miss, requests the whole block from `Imem` over the `ren`/`block_address`/`ready`/`dout` handshake. It writes the returned block into its data array, then releases the core's stall.

## Interface
- `SETS`, 16: number of lines; power of two, at least 2.
- `WORD_BITS`, 32: instruction width. `IBLOCK_SIZE_BITS` must be a power-of-two multiple of it.
- `ADDR_BITS`, 32: byte-address width of `cpu_addr`.
- `clock`  in  1: single clock; all state is updated on its rising edge.
- `reset`  in  1: asynchronous, active-low; clears all state.
- `cpu_ren`  in  1: fetch request.
- `cpu_addr`  in  ADDR_BITS: byte address of the fetch; word-aligned.
- `flush`  in  1: invalidate all lines.
- `cpu_instr`  out  WORD_BITS: fetched instruction; valid when `cpu_ren & ~cpu_stall`.
- `cpu_stall`  out  1: core must hold `cpu_addr`/`cpu_ren`/`flush` stable while this is 1.
- `mem_ren`  out  1: block read request to `Imem`.
- `mem_block_address`  out  `IMEM_BLOCK_ADDR_SIZE`: requested block number.
- `mem_ready`  in  1: `Imem` data valid.
- `mem_dout`  in  `IBLOCK_SIZE_BITS`: returned block.

## Operation
- Address split, LSB first:
  - 2 byte-offset bits (ignored).
  - `log2(IBLOCK_SIZE_BITS/WORD_BITS)` word-offset bits.
  - `log2(SETS)` index bits.
  - Remaining upper bits are the tag.
- `mem_block_address` is `cpu_addr >> (byte+word offset bits)`, truncated to `IMEM_BLOCK_ADDR_SIZE` bits. It is captured into a register at the miss.
- Arrays: `valid[SETS]` (reset to 0), `tag[SETS]`, `data[SETS]` (full block). The `tag` and `data` arrays are not reset.
- Hit is combinational: `cpu_ren & valid[idx] & tag[idx]==tag`. `cpu_instr` is the selected word of `data[idx]`.
- FSM:
  - **IDLE**:
    - `mem_ren`=0.
    - Flush takes priority over a miss: if `flush`, clear all `valid` at the edge and stay in IDLE, with `cpu_stall`=1 that cycle.
    - Otherwise, on `cpu_ren` & miss: latch index, tag and block address, then go to REFILL.
    - `cpu_stall` = `cpu_ren & ~hit` | `flush`.
  - **REFILL**:
    - `mem_ren`=1; `mem_block_address` is held from the latched register.
    - `cpu_stall`=1.
    - On `mem_ready`=1: write `mem_dout` to `data[latched idx]`, write the latched tag, set `valid`, then go to RELEASE.
  - **RELEASE**:
    - `mem_ren`=0 for exactly one cycle. This resets the `Imem` delay counter, so every refill sees the full memory latency.
    - `cpu_stall`=1; then go to IDLE.
- `flush` is sampled only in IDLE.
- `cpu_addr` changes while stalled are a protocol violation. The refill always completes to the latched address.
- When `cpu_ren`=0 in IDLE: no lookup side effects and `cpu_stall`=0, unless `flush` is asserted.

## Timing
- Reset values:
  - `mem_ren`=0, `mem_block_address`=0, state IDLE, all `valid`=0.
  - `cpu_stall` = `cpu_ren | flush` (every access misses after reset).
  - `cpu_instr` is undefined while `cpu_stall`=1.
- Hit latency is 0 cycles: the instruction is valid in the same cycle as the request.
- Miss timing, where the miss is seen in IDLE at edge E0:
  - `mem_ren` rises after E0.
  - `mem_ready` rises N cycles later, where N is the `Imem` latency.
  - The fill happens at the first edge where `mem_ready`=1.
  - RELEASE lasts one cycle.
  - IDLE re-lookup hits and `cpu_stall` drops. Total stall is N+3 cycles.
- `mem_dout` is sampled only on an edge where REFILL and `mem_ready`=1 both hold. `mem_ready` outside REFILL is ignored.
- Reset asserted mid-refill: asynchronous return to IDLE, `mem_ren`=0, all `valid` cleared. The partial refill is discarded.

## Configuration
- `ICACHE_STATS_EN` defined:
  - Adds outputs `hit_count` and `miss_count`, 32 bits each, reset to 0.
  - `hit_count` increments on IDLE & `cpu_ren` & hit & ~`flush`.
  - `miss_count` increments on the IDLE→REFILL transition.
  - Both counters wrap at 2^32.
- `ICACHE_STATS_EN` undefined: the ports and counters are absent, and behaviour is otherwise identical.

## Structure
- Constants go in the shared `constants.vh`: `ICACHE_SETS`, `ICACHE_INDEX_SIZE`, `ICACHE_TAG_SIZE`, `IBLOCK_WORDS`, `IBLOCK_WORD_OFF_SIZE`, and the FSM state encodings `IC_IDLE`, `IC_REFILL`, `IC_RELEASE`.
- One sub-module, `icache_array`: the valid/tag/data storage. It has one combinational read port, one synchronous write port, and a synchronous valid-clear-all input.

## Test plan
Bench parameters: `IBLOCK_SIZE_BITS`=128, `SETS`=16, `Imem` latency N=3.

1. **Cold miss.** After reset, `cpu_addr`=0x0000_0010 with `cpu_ren`=1 → `cpu_stall`=1 for 6 cycles; `mem_block_address`=1; `mem_ren` high for exactly 4 cycles; then `cpu_instr` = word 0 of block 1 with `cpu_stall`=0.
2. **Sequential hits.** Fetch 0x14, 0x18, 0x1C next → three consecutive zero-stall hits returning words 1, 2 and 3 of block 1; `mem_ren` stays 0.
3. **Conflict eviction.** Fetch 0x110 (same index, different tag) → miss and refill of block 0x11. A re-fetch of 0x10 then misses again.
4. **Flush.** With `flush`=1 for one cycle in IDLE → all lines invalid; the next fetch of 0x10 misses.
5. **Reset mid-refill.** Deassert `reset` during REFILL → `mem_ren`=0 immediately; after release, fetch 0x10 misses.
6. **Stats (`ICACHE_STATS_EN`).** After scenarios 1–2 → `hit_count`=4 and `miss_count`=1. The count of 4 includes the post-fill hit.
